mem_req_arbiter: RTL and testbench

//  Shares one downstream sram-like memory port between the fetch requester (inst_*) and the
//  EXE-stage load/store requester (data_*). Locks the grant until addr_ok and records each

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_id_fifo.sv | 54 +++++
 rtl/mem_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared owner IDs, arbiter state encodings and the request field bundle
// used by mem_req_arbiter and its ID FIFO.
package mem_arb_pkg;

   // Owner of an accepted request, stored in the in-order ID FIFO
   localparam logic ARB_ID_INST = 1'b0;
   localparam logic ARB_ID_DATA = 1'b1;

   // Arbiter FSM encodings
   localparam logic [1:0] ARB_IDLE   = 2'd0;
   localparam logic [1:0] ARB_HOLD_I = 2'd1;
   localparam logic [1:0] ARB_HOLD_D = 2'd2;

   // Request fields forwarded from the granted requester to the memory port
   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_fields_t;

endpackage

// File: rtl/arb_id_fifo.sv
// 1-bit-wide in-order owner-ID FIFO. Records which requester owns each
// accepted-but-unanswered memory request; head is the owner of the next
// response. Pointers wrap modulo DEPTH.
module arb_id_fifo #(
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          push,
   input  logic          push_id,
   input  logic          pop,
   output logic          head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [DEPTH-1:0] id_mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Storage, pointers and occupancy; simultaneous push and pop keep count
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         id_mem <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            id_mem[wr_ptr] <= push_id;
            wr_ptr         <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Status flags derived from the registered occupancy
   always_comb begin
      head  = id_mem[rd_ptr];
      full  = (count == CW'(DEPTH));
      empty = (count == '0);
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like memory port between the fetch (inst_*) and the
// load/store (data_*) requesters. The grant is locked until mem_addr_ok,
// each accept records its owner in an in-order ID FIFO, and responses are
// routed back to the FIFO head owner with zero latency.
// Build option: ARB_ROUND_ROBIN_EN selects alternating tie-break instead of
// fixed data-over-inst priority.
//
// Handshake: a requester holds req and its fields stable until it sees its
// addr_ok; a transfer happens in the cycle where mem_req & mem_addr_ok.
// Responses (mem_data_ok) arrive in request order and are not back-pressured.
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int OUTSTANDING = 4,
   localparam int CW          = $clog2(OUTSTANDING) + 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          inst_req,
   input  logic          inst_wr,
   input  logic [1:0]    inst_size,
   input  logic [3:0]    inst_wstrb,
   input  logic [31:0]   inst_addr,
   input  logic [31:0]   inst_wdata,
   output logic          inst_addr_ok,
   output logic          inst_data_ok,
   output logic [31:0]   inst_rdata,
   input  logic          data_req,
   input  logic          data_wr,
   input  logic [1:0]    data_size,
   input  logic [3:0]    data_wstrb,
   input  logic [31:0]   data_addr,
   input  logic [31:0]   data_wdata,
   output logic          data_addr_ok,
   output logic          data_data_ok,
   output logic [31:0]   data_rdata,
   output logic          mem_req,
   output logic          mem_wr,
   output logic [1:0]    mem_size,
   output logic [3:0]    mem_wstrb,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic          mem_addr_ok,
   input  logic          mem_data_ok,
   input  logic [31:0]   mem_rdata,
   output logic [CW-1:0] outstanding,
   output logic          proto_err,
   output logic [1:0]    arb_state
);

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic        idle_pick;
   logic        grant_vld;
   logic        grant_id;
   logic        accept;
   logic        pop;
   logic        fifo_head;
   logic        fifo_full;
   logic        fifo_empty;
   req_fields_t inst_f;
   req_fields_t data_f;
   req_fields_t mem_f;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant;

   // Tie goes to whoever was not granted last; a lone requester always wins
   always_comb begin
      if (inst_req && data_req) idle_pick = ~last_grant;
      else                      idle_pick = data_req ? ARB_ID_DATA : ARB_ID_INST;
   end

   // Remember the owner of the most recent accept
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)     last_grant <= ARB_ID_INST;
      else if (accept) last_grant <= grant_id;
   end
`else
   // Fixed priority: load/store beats fetch
   always_comb idle_pick = data_req ? ARB_ID_DATA : ARB_ID_INST;
`endif

   // Grant: free choice in IDLE (blocked when full), locked owner in HOLD
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = idle_pick;
      case (state)
         ARB_IDLE:   grant_vld = ~fifo_full & (inst_req | data_req);
         ARB_HOLD_I: begin grant_vld = 1'b1; grant_id = ARB_ID_INST; end
         ARB_HOLD_D: begin grant_vld = 1'b1; grant_id = ARB_ID_DATA; end
         default:    grant_vld = 1'b0;
      endcase
   end

   // Field mux towards the memory port and addr_ok demux back to the winner
   always_comb begin
      inst_f       = '{inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
      data_f       = '{data_wr, data_size, data_wstrb, data_addr, data_wdata};
      mem_f        = (grant_id == ARB_ID_DATA) ? data_f : inst_f;
      mem_req      = grant_vld;
      mem_wr       = mem_f.wr;
      mem_size     = mem_f.size;
      mem_wstrb    = mem_f.wstrb;
      mem_addr     = mem_f.addr;
      mem_wdata    = mem_f.wdata;
      accept       = grant_vld & mem_addr_ok;
      inst_addr_ok = accept & (grant_id == ARB_ID_INST);
      data_addr_ok = accept & (grant_id == ARB_ID_DATA);
   end

   // Response demux: the FIFO head names the owner of this response
   always_comb begin
      pop          = mem_data_ok & ~fifo_empty;
      inst_data_ok = pop & (fifo_head == ARB_ID_INST);
      data_data_ok = pop & (fifo_head == ARB_ID_DATA);
      inst_rdata   = mem_rdata;
      data_rdata   = mem_rdata;
   end

   // Next state: lock onto the winner until the memory accepts it
   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: begin
            if (grant_vld && !mem_addr_ok)
               state_nxt = (grant_id == ARB_ID_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
         end
         ARB_HOLD_I, ARB_HOLD_D: begin
            if (mem_addr_ok) state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ARB_IDLE;
      else         state <= state_nxt;
   end

   // Sticky flag for a response that arrived with nothing outstanding
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                        proto_err <= 1'b0;
      else if (mem_data_ok && fifo_empty) proto_err <= 1'b1;
   end

   // Debug view of the arbiter state
   always_comb arb_state = state;

   arb_id_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_id_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (accept),
      .push_id (grant_id),
      .pop     (pop),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (outstanding)
   );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: table-driven single-transaction
// vectors, hand-written multi-cycle sequences, and a randomized phase checked
// against a queue-based reference model. Honours ARB_ROUND_ROBIN_EN.
module tb_mem_req_arbiter;

   localparam int OUT = 4;
   localparam logic [31:0] IA = 32'h1000_0040;
   localparam logic [31:0] DA = 32'h2000_0080;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inst_req = 0, inst_wr = 0;
   logic [1:0]  inst_size = 2'd2;
   logic [3:0]  inst_wstrb = 4'hf;
   logic [31:0] inst_addr = IA, inst_wdata = 32'h1111_1111;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req = 0, data_wr = 0;
   logic [1:0]  data_size = 2'd2;
   logic [3:0]  data_wstrb = 4'hf;
   logic [31:0] data_addr = DA, data_wdata = 32'h2222_2222;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok = 0, mem_data_ok = 0;
   logic [31:0] mem_rdata = 32'h0;
   logic [2:0]  outstanding;
   logic        proto_err;
   logic [1:0]  arb_state;

   int checks = 0;
   int errors = 0;

   // Clock
   always #5 clk = ~clk;

   mem_req_arbiter #(.OUTSTANDING(OUT)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .outstanding(outstanding), .proto_err(proto_err), .arb_state(arb_state)
   );

   typedef struct {
      bit          i_req;
      bit          d_req;
      bit          mao;
      bit          e_mem_req;
      bit          e_winner;   // 0 = inst, 1 = data
      logic [31:0] e_addr;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Start a cycle: inputs change just after the falling edge
   task automatic drive(input bit ir, input bit dr, input bit mao, input bit mdo);
      @(negedge clk);
      inst_req    = ir;
      data_req    = dr;
      mem_addr_ok = mao;
      mem_data_ok = mdo;
      mem_rdata   = $urandom;
      #1;
   endtask

   // One response pulse, checked against the expected owner
   task automatic pop_check(input bit owner);
      drive(0, 0, 0, 1);
      chk("resp_inst_data_ok", inst_data_ok, owner == 1'b0);
      chk("resp_data_data_ok", data_data_ok, owner == 1'b1);
      chk("resp_rdata", owner ? data_rdata : inst_rdata, mem_rdata);
   endtask

   task automatic do_reset();
      @(negedge clk);
      inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
      resetn = 0;
      @(negedge clk);
      resetn = 1;
   endtask

   // Reference model state: owner queue, locked owner (-1 none), last grant
   bit m_q[$];
   int m_lock;
   bit m_last;
   bit m_proto;

   initial begin
      bit ip, dp, e_req, e_own, e_acc, e_pop;
      int n;

      // Reset state
      #2;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_proto_err", proto_err, 0);
      chk("rst_state", arb_state, 0);
      chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
      chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
      do_reset();

      // Table: each vector starts from IDLE with an empty FIFO
      vecs[0] = '{0, 0, 1, 0, 0, IA};
      vecs[1] = '{1, 0, 1, 1, 0, IA};
      vecs[2] = '{0, 1, 1, 1, 1, DA};
      vecs[3] = RR ? '{1, 1, 1, 1, 0, IA} : '{1, 1, 1, 1, 1, DA};
      vecs[4] = '{1, 1, 0, 1, 1, DA};
      vecs[5] = '{1, 0, 0, 1, 0, IA};
      vecs[6] = '{0, 1, 0, 1, 1, DA};
      vecs[7] = RR ? '{1, 1, 1, 1, 0, IA} : '{1, 1, 1, 1, 1, DA};
      for (int v = 0; v < 8; v++) begin
         drive(vecs[v].i_req, vecs[v].d_req, vecs[v].mao, 0);
         chk($sformatf("v%0d_mem_req", v), mem_req, vecs[v].e_mem_req);
         chk($sformatf("v%0d_inst_addr_ok", v), inst_addr_ok,
             vecs[v].e_mem_req & vecs[v].mao & !vecs[v].e_winner);
         chk($sformatf("v%0d_data_addr_ok", v), data_addr_ok,
             vecs[v].e_mem_req & vecs[v].mao & vecs[v].e_winner);
         if (vecs[v].e_mem_req) chk($sformatf("v%0d_mem_addr", v), mem_addr, vecs[v].e_addr);
         if (vecs[v].e_mem_req && !vecs[v].mao) begin
            // Locked: winner still presented and accepted on the next addr_ok
            drive(vecs[v].i_req, vecs[v].d_req, 1, 0);
            chk($sformatf("v%0d_hold_addr", v), mem_addr, vecs[v].e_addr);
            chk($sformatf("v%0d_hold_ok", v), {inst_addr_ok, data_addr_ok},
                vecs[v].e_winner ? 2'b01 : 2'b10);
         end
         if (vecs[v].e_mem_req) pop_check(vecs[v].e_winner);
         drive(0, 0, 0, 0);
         chk($sformatf("v%0d_drained", v), outstanding, 0);
      end

      // Lock: inst held 3 cycles, data arrives in cycle 2
      drive(1, 0, 0, 0);
      chk("hold_c1_addr", mem_addr, IA);
      chk("hold_c1_ok", {inst_addr_ok, data_addr_ok}, 0);
      drive(1, 1, 0, 0);
      chk("hold_c2_addr", mem_addr, IA);
      chk("hold_c2_state", arb_state, 1);
      drive(1, 1, 0, 0);
      chk("hold_c3_addr", mem_addr, IA);
      chk("hold_c3_ok", {inst_addr_ok, data_addr_ok}, 0);
      drive(1, 1, 1, 0);
      chk("hold_c4_inst_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
      drive(0, 1, 1, 0);
      chk("hold_c5_data_ok", {inst_addr_ok, data_addr_ok}, 2'b01);
      chk("hold_c5_addr", mem_addr, DA);
      pop_check(0);
      pop_check(1);

      // Fill to OUTSTANDING with I,D,I,D then a blocked 5th request
      for (int k = 0; k < OUT; k++) begin
         drive(k % 2 == 0, k % 2 == 1, 1, 0);
         chk($sformatf("fill%0d_ok", k), {inst_addr_ok, data_addr_ok},
             (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      drive(1, 0, 1, 1);
      chk("full_outstanding", outstanding, 4);
      chk("full_mem_req", mem_req, 0);
      chk("full_inst_addr_ok", inst_addr_ok, 0);
      chk("full_pop_inst", inst_data_ok, 1);
      drive(0, 0, 0, 0);
      chk("full_pop_count", outstanding, 3);
      pop_check(1);
      pop_check(0);
      pop_check(1);
      drive(0, 0, 0, 0);
      chk("empty_again", outstanding, 0);

      // Accept and response in the same cycle at count 2
      drive(1, 0, 1, 0);
      drive(0, 1, 1, 0);
      drive(0, 1, 1, 1);
      chk("c2_outstanding", outstanding, 2);
      chk("c2_data_addr_ok", data_addr_ok, 1);
      chk("c2_inst_data_ok", inst_data_ok, 1);
      drive(0, 0, 0, 0);
      chk("c2_count_kept", outstanding, 2);
      pop_check(1);
      pop_check(1);

      // Response with nothing outstanding
      drive(0, 0, 0, 1);
      chk("orphan_data_ok", {inst_data_ok, data_data_ok}, 0);
      drive(0, 0, 0, 0);
      chk("orphan_proto_set", proto_err, 1);
      drive(0, 0, 0, 0);
      chk("orphan_proto_held", proto_err, 1);
      #1 resetn = 0;
      #1;
      chk("async_reset_proto", proto_err, 0);
      @(negedge clk);
      resetn = 1;

`ifdef ARB_ROUND_ROBIN_EN
      // Both requesters held with addr_ok high: grants alternate D,I,D,I
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 1, 0);
         chk($sformatf("rr%0d_ok", k), {inst_addr_ok, data_addr_ok},
             (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      pop_check(1);
      pop_check(0);
      pop_check(1);
      pop_check(0);
`endif

      // Randomized phase against the reference model
      do_reset();
      m_q.delete();
      m_lock = -1;
      m_last = 1'b0;
      m_proto = 1'b0;
      ip = 0;
      dp = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1; inst_addr = $urandom; inst_wdata = $urandom; inst_wr = 1'($urandom_range(0, 1));
         end
         if (!dp && $urandom_range(0, 2) == 0) begin
            dp = 1; data_addr = $urandom; data_wdata = $urandom; data_wr = 1'($urandom_range(0, 1));
         end
         inst_req    = ip;
         data_req    = dp;
         mem_addr_ok = ($urandom_range(0, 3) != 0);
         mem_data_ok = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 149) == 0);
         mem_rdata   = $urandom;
         #1;
         n = m_q.size();
         e_req = 0;
         e_own = 0;
         if (m_lock >= 0) begin
            e_req = 1;
            e_own = (m_lock == 1);
         end else if (n < OUT && (ip || dp)) begin
            e_req = 1;
            e_own = (ip && dp) ? (RR ? !m_last : 1'b1) : dp;
         end
         e_acc = e_req & mem_addr_ok;
         e_pop = mem_data_ok && n > 0;
         chk("rnd_mem_req", mem_req, e_req);
         if (e_req) begin
            chk("rnd_mem_addr", mem_addr, e_own ? data_addr : inst_addr);
            chk("rnd_mem_wdata", mem_wdata, e_own ? data_wdata : inst_wdata);
            chk("rnd_mem_wr", mem_wr, e_own ? data_wr : inst_wr);
         end
         chk("rnd_addr_ok", {inst_addr_ok, data_addr_ok}, {e_acc & !e_own, e_acc & e_own});
         chk("rnd_data_ok", {inst_data_ok, data_data_ok},
             {e_pop && m_q[0] == 1'b0, e_pop && m_q[0] == 1'b1});
         chk("rnd_outstanding", outstanding, n);
         chk("rnd_proto_err", proto_err, m_proto);
         // Advance the model to the state after this edge
         if (mem_data_ok && n == 0) m_proto = 1;
         if (e_pop) m_q.delete(0);
         if (e_acc) begin
            m_q.push_back(e_own);
            m_last = e_own;
            if (e_own) dp = 0; else ip = 0;
         end
         if (m_lock >= 0 && mem_addr_ok) m_lock = -1;
         else if (m_lock < 0 && e_req && !mem_addr_ok) m_lock = e_own ? 1 : 0;
      end
      drive(0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
